// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_pkg
// Description : Shared geometry, character codes and state encoding for the
//               text console writer and the tile layer that renders from it.
// Revision    : 1.0 - initial release
// ============================================================================
package text_pkg;

  // Text buffer geometry: 16 rows of 32 columns
  localparam int TEXT_COL_BITS = 5;
  localparam int TEXT_ROW_BITS = 4;
  localparam int TEXT_ADDR_W   = TEXT_ROW_BITS + TEXT_COL_BITS;

  // Character codes with special handling
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_DEL   = 8'h7F;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // Writer state encoding
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage : text_pkg
`default_nettype wire

// File: rtl/text_cursor.sv
`default_nettype none
// ============================================================================
// Module      : text_cursor
// Description : Row/column cursor registers with column wrap and row wrap.
//               Commands are mutually exclusive in practice; home has top
//               priority so a screen clear always lands at (0,0).
// Revision    : 1.0 - initial release
// ============================================================================
module text_cursor
  import text_pkg::*;
#(
  parameter int COL_BITS = TEXT_COL_BITS,
  parameter int ROW_BITS = TEXT_ROW_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance,
  input  logic                newline,
  input  logic                cr,
  input  logic                back,
  input  logic                home,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col
);

  // Cursor update; counters wrap by natural modulo overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (home) begin
      row <= '0;
      col <= '0;
    end else if (newline) begin
      row <= row + ROW_BITS'(1);
      col <= '0;
    end else if (cr) begin
      col <= '0;
    end else if (back) begin
      col <= col - COL_BITS'(1);
    end else if (advance) begin
      col <= col + COL_BITS'(1);
      if (col == {COL_BITS{1'b1}}) begin
        row <= row + ROW_BITS'(1);
      end
    end
  end

endmodule : text_cursor
`default_nettype wire

// File: rtl/text_console_writer.sv
`default_nettype none
// ============================================================================
// Module      : text_console_writer
// Description : Consumes a character stream, keeps a cursor and drives the
//               text buffer RAM write port. Clears the whole buffer after
//               reset and on form feed.
// Revision    : 1.0 - initial release
// ============================================================================
module text_console_writer
  import text_pkg::*;
#(
  parameter int         COL_BITS   = TEXT_COL_BITS,
  parameter int         ROW_BITS   = TEXT_ROW_BITS,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                         i_pix_clk,
  input  logic                         i_reset_n,
  input  logic                         i_char_valid,
  input  logic [7:0]                   i_char,
  output logic                         o_char_ready,
  output logic                         o_wr_en,
  output logic [ROW_BITS+COL_BITS-1:0] o_wr_addr,
  output logic [7:0]                   o_wr_data,
  output logic [ROW_BITS-1:0]          o_cursor_row,
  output logic [COL_BITS-1:0]          o_cursor_col,
  output logic                         o_busy
);

  localparam int ADDR_W = ROW_BITS + COL_BITS;
  // One extra bit so reaching the end of the buffer is visible as the MSB
  localparam int CLR_W  = ADDR_W + 1;

  state_t              state;
  logic [CLR_W-1:0]    clr_cnt;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [COL_BITS-1:0] col_prev;
  logic                xfer;
  logic                is_print;
  logic                do_adv;
  logic                do_nl;
  logic                do_cr;
  logic                do_back;
  logic                do_home;

  // Character decode for the transfer happening on this edge
  always_comb begin
    xfer     = i_char_valid && (state == ST_IDLE);
    is_print = (i_char >= CH_SPACE) && (i_char != CH_DEL);
    col_prev = col - COL_BITS'(1);
    do_adv   = xfer && is_print;
    do_nl    = xfer && (i_char == CH_LF);
    do_cr    = xfer && (i_char == CH_CR);
    do_back  = xfer && (i_char == CH_BS) && (col != '0);
    do_home  = xfer && (i_char == CH_FF);
  end

  text_cursor #(
    .COL_BITS (COL_BITS),
    .ROW_BITS (ROW_BITS)
  ) u_cursor (
    .clk     (i_pix_clk),
    .rst_n   (i_reset_n),
    .advance (do_adv),
    .newline (do_nl),
    .cr      (do_cr),
    .back    (do_back),
    .home    (do_home),
    .row     (row),
    .col     (col)
  );

  // State machine, clear counter and registered write port
  always_ff @(posedge i_pix_clk) begin
    if (!i_reset_n) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else if (state == ST_IDLE) begin
      o_wr_en <= 1'b0;
      if (do_home) begin
        // Form feed: the first clear write goes out right away
        state     <= ST_CLEAR;
        clr_cnt   <= CLR_W'(1);
        o_wr_en   <= 1'b1;
        o_wr_addr <= '0;
        o_wr_data <= CLEAR_CHAR;
      end else if (do_adv) begin
        o_wr_en   <= 1'b1;
        o_wr_addr <= {row, col};
        o_wr_data <= i_char;
      end else if (do_back) begin
        o_wr_en   <= 1'b1;
        o_wr_addr <= {row, col_prev};
        o_wr_data <= CLEAR_CHAR;
      end
    end else begin
      if (clr_cnt[CLR_W-1]) begin
        state   <= ST_IDLE;
        o_wr_en <= 1'b0;
      end else begin
        o_wr_en   <= 1'b1;
        o_wr_addr <= clr_cnt[ADDR_W-1:0];
        o_wr_data <= CLEAR_CHAR;
        clr_cnt   <= clr_cnt + CLR_W'(1);
      end
    end
  end

  assign o_char_ready = (state == ST_IDLE);
  assign o_busy       = (state == ST_CLEAR);
  assign o_cursor_row = row;
  assign o_cursor_col = col;

endmodule : text_console_writer
`default_nettype wire

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Writes into the 16x32 text buffer that the tile layer renders from.
- Accepts a stream of character codes over a valid/ready handshake and keeps a cursor (row, col).
- Emits one-cycle write strobes to the text buffer RAM write port, at address {row[3:0], col[4:0]}.
- Handles printable characters, LF, CR, backspace, and a form-feed screen clear. Also clears the whole buffer after reset.

Parameters:
- COL_BITS, 5, log2 of columns (32).
- ROW_BITS, 4, log2 of rows (16).
- CLEAR_CHAR, 8'h20, code written to cells by clear and by backspace.

Ports:
- i_pix_clk  in  1  system/pixel clock; all logic on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_char_valid  in  1  character offered.
- i_char  in  8  character code.
- o_char_ready  out  1  block can accept a character this cycle.
- o_wr_en  out  1  text buffer write strobe, one cycle per write.
- o_wr_addr  out  ROW_BITS+COL_BITS (9)  text buffer address {row, col}.
- o_wr_data  out  8  data to write.
- o_cursor_row  out  ROW_BITS  current cursor row.
- o_cursor_col  out  COL_BITS  current cursor column.
- o_busy  out  1  clear sequence in progress.

Behaviour:
- Reset: synchronous, active-low.
  - While i_reset_n=0: o_wr_en=0, o_wr_addr=0, o_wr_data=0, cursor (0,0), o_char_ready=0, o_busy=1.
  - State goes to CLEAR with the clear counter at 0.
- States: CLEAR and IDLE.
  - o_char_ready = (state==IDLE).
  - o_busy = (state==CLEAR).
- Transfer rule:
  - A transfer happens on a rising edge where i_char_valid && o_char_ready.
  - Any resulting write appears on o_wr_* in the cycle after the transfer; latency is 1 cycle.
  - Cursor outputs update in that same cycle.
  - Throughput is 1 char/cycle in IDLE.
- o_wr_* are registered. o_wr_en is high for exactly one cycle per write. o_wr_addr and o_wr_data hold their last values when o_wr_en=0.
- Character decode on transfer (cursor = (r,c)):
  - 0x20..0x7E and 0x80..0xFF: write {r,c} <= i_char, then advance the cursor.
    - c<31: c+1.
    - c==31: c=0, row advances.
    - Row advance: r+1, and r==15 wraps to 0. There is no scrolling.
  - 0x0A (LF): no write; c=0, row advance (with wrap).
  - 0x0D (CR): no write; c=0.
  - 0x08 (BS):
    - If c>0: c-1, and write CLEAR_CHAR at {r,c-1}.
    - If c==0: no write, cursor unchanged. Backspace never moves to the previous row.
  - 0x0C (FF): enter CLEAR.
  - All other codes 0x00..0x1F and 0x7F: consumed, no write, cursor unchanged.
- CLEAR sequence:
  - Writes CLEAR_CHAR to addresses 0..511 in ascending order, one per cycle, 512 consecutive o_wr_en cycles.
  - The first write is visible in the cycle after FF acceptance, or after the first edge with reset released.
  - o_char_ready=0 throughout. o_char_ready=1 in the cycle after the write to 511.
  - Cursor is forced to (0,0) on entry to CLEAR.
  - Characters presented during CLEAR are not consumed; i_char_valid may stay high.
- Reset during CLEAR aborts the sequence; the clear restarts from address 0 after release.
- Reset in IDLE with a pending write: the write is dropped; o_wr_en=0 in the next cycle.
- Arithmetic:
  - Column and row counters are exactly COL_BITS and ROW_BITS wide; wrap is natural modulo overflow.
  - The clear counter is ROW_BITS+COL_BITS+1 bits so the end-of-clear is detectable without aliasing.

Decomposition:
- Shared package text_pkg:
  - COL_BITS and ROW_BITS defaults, TEXT_ADDR_W=9.
  - Character constants CH_LF=8'h0A, CH_CR=8'h0D, CH_BS=8'h08, CH_FF=8'h0C, CH_DEL=8'h7F, CH_SPACE=8'h20.
  - State encoding ST_IDLE and ST_CLEAR.
  - The tile layer takes its buffer geometry from the same package.
- One sub-module, text_cursor:
  - Holds the row/col registers.
  - Takes advance/newline/cr/back/home commands.
  - Outputs the current cursor position.
  - Implements the wrap rules.
  - The top level holds the FSM, clear counter, and write-port registers.

Test Plan:
- Reset released -> o_wr_en high 512 consecutive cycles, addr 0..511, data 0x20. Then o_char_ready=1, o_busy=0, cursor (0,0).
- 'H' (0x48) then 'i' (0x69) on back-to-back cycles -> writes addr 0=0x48, addr 1=0x69 on consecutive cycles; cursor (0,2).
- Column and screen wrap:
  - Cursor (0,31), send 'A' -> write addr 31=0x41; cursor (1,0).
  - Cursor (15,31), send 'B' -> write addr 511=0x42; cursor (0,0).
- Control codes:
  - LF at (2,5) -> no write, cursor (3,0).
  - CR at (3,4) -> cursor (3,0).
  - LF at (15,7) -> cursor (0,0).
  - 0x07 and 0x7F -> accepted, no write, cursor unchanged.
- Backspace:
  - BS at (1,3) -> write addr 0x22=0x20; cursor (1,2).
  - BS at (4,0) -> no write, cursor (4,0).
- FF, then further chars:
  - FF at (5,9) with 'Z' held valid -> ready low, 512 clear writes, cursor (0,0). Then 'Z' written to addr 0; cursor (0,1).
  - Reset pulsed after the clear write to addr 100 -> after release, the clear restarts at addr 0 and runs the full 512 writes.
